// File: rtl/synapse_pkg.sv
// Shared types and default parameters for the synapse accumulator.
package synapse_pkg;

  localparam int unsigned N_CONN_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned W_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  // One connection-table entry at the default widths.
  typedef struct packed {
    logic                         en;
    logic [ADDR_W_DEF-1:0]        addr;
    logic signed [W_W_DEF-1:0]    weight;
  } entry_t;

endpackage

// File: rtl/synapse_accumulator_if.sv
// Configuration, spike and result signals of the synapse accumulator.
interface synapse_accumulator_if #(
  parameter int unsigned N_CONN = synapse_pkg::N_CONN_DEF,
  parameter int unsigned ADDR_W = synapse_pkg::ADDR_W_DEF,
  parameter int unsigned W_W    = synapse_pkg::W_W_DEF
);
  localparam int unsigned IDX_W = $clog2(N_CONN);
  localparam int unsigned ACC_W = W_W + IDX_W;

  logic                    cfg_we;
  logic [IDX_W-1:0]        cfg_idx;
  logic [ADDR_W-1:0]       cfg_addr;
  logic signed [W_W-1:0]   cfg_weight;
  logic                    cfg_en;
  logic                    spike_valid;
  logic [ADDR_W-1:0]       spike_addr;
  logic                    timestep_end;
  logic                    acc_valid;
  logic signed [ACC_W-1:0] acc_data;
  logic                    acc_ready;
  logic                    busy;
  logic                    err_overrun;

  modport master (
    output cfg_we, cfg_idx, cfg_addr, cfg_weight, cfg_en,
    output spike_valid, spike_addr, timestep_end, acc_ready,
    input  acc_valid, acc_data, busy, err_overrun
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_addr, cfg_weight, cfg_en,
    input  spike_valid, spike_addr, timestep_end, acc_ready,
    output acc_valid, acc_data, busy, err_overrun
  );

endinterface

// File: rtl/synapse_cam.sv
// Connection table with a parallel address compare and an indexed weight read port.
module synapse_cam #(
  parameter int unsigned N_CONN = synapse_pkg::N_CONN_DEF,
  parameter int unsigned ADDR_W = synapse_pkg::ADDR_W_DEF,
  parameter int unsigned W_W    = synapse_pkg::W_W_DEF,
  parameter int unsigned IDX_W  = $clog2(N_CONN)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_valid_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic                  wr_entry_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic signed [W_W-1:0] wr_weight_i,
  input  logic                  lk_valid_i,
  input  logic [ADDR_W-1:0]     lk_addr_i,
  output logic [N_CONN-1:0]     hit_c_o,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic signed [W_W-1:0] rd_weight_c_o
);

  logic [N_CONN-1:0]     en_q;
  logic [ADDR_W-1:0]     addr_q   [N_CONN];
  logic signed [W_W-1:0] weight_q [N_CONN];

  // Only the enable bits are reset; addr/weight are don't-care while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_CONN); i++) begin
        if (wr_valid_i && (wr_idx_i == IDX_W'(i))) en_q[i] <= wr_entry_en_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(N_CONN); i++) begin
      if (wr_valid_i && (wr_idx_i == IDX_W'(i))) begin
        addr_q[i]   <= wr_addr_i;
        weight_q[i] <= wr_weight_i;
      end
    end
  end

  always_comb begin
    hit_c_o = '0;
    for (int i = 0; i < int'(N_CONN); i++) begin
      hit_c_o[i] = lk_valid_i && en_q[i] && (addr_q[i] == lk_addr_i);
    end
  end

  assign rd_weight_c_o = weight_q[rd_idx_i];

endmodule

// File: rtl/synapse_accumulator.sv
// Per-timestep weighted spike accumulator: snapshot matched spikes, sum weights serially, hand out result.
module synapse_accumulator
  import synapse_pkg::*;
#(
  parameter int unsigned N_CONN = N_CONN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned W_W    = W_W_DEF
) (
  input  logic                  CLK_Mac,
  input  logic                  RST_Mac_n,
  synapse_accumulator_if.slave  syn_if
);

  localparam int unsigned IDX_W = $clog2(N_CONN);
  localparam int unsigned ACC_W = W_W + IDX_W;

  state_e                  state_q, state_d;
  logic [N_CONN-1:0]       incoming_q, incoming_d;
  logic [N_CONN-1:0]       active_q, active_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_data_q, acc_data_d;
  logic                    acc_valid_q, acc_valid_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic [N_CONN-1:0]       hit_c;
  logic signed [W_W-1:0]   weight_c;
  logic signed [ACC_W-1:0] sum_c;
  logic                    last_idx_c;
  logic                    cfg_wr_c;

  assign cfg_wr_c   = syn_if.cfg_we && (state_q == ST_IDLE);
  assign last_idx_c = (idx_q == IDX_W'(N_CONN - 1));
  assign sum_c      = active_q[idx_q] ? (acc_q + ACC_W'(weight_c)) : acc_q;

  synapse_cam #(
    .N_CONN (N_CONN),
    .ADDR_W (ADDR_W),
    .W_W    (W_W),
    .IDX_W  (IDX_W)
  ) u_cam (
    .clk_i         (CLK_Mac),
    .rst_ni        (RST_Mac_n),
    .wr_valid_i    (cfg_wr_c),
    .wr_idx_i      (syn_if.cfg_idx),
    .wr_entry_en_i (syn_if.cfg_en),
    .wr_addr_i     (syn_if.cfg_addr),
    .wr_weight_i   (syn_if.cfg_weight),
    .lk_valid_i    (syn_if.spike_valid),
    .lk_addr_i     (syn_if.spike_addr),
    .hit_c_o       (hit_c),
    .rd_idx_i      (idx_q),
    .rd_weight_c_o (weight_c)
  );

  // State register
  always_ff @(posedge CLK_Mac or negedge RST_Mac_n) begin
    if (!RST_Mac_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (syn_if.timestep_end) state_d = ST_ACCUM;
      ST_ACCUM:  if (last_idx_c)          state_d = ST_OUTPUT;
      ST_OUTPUT: if (syn_if.acc_ready)    state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; spikes always fold into incoming[]
  always_comb begin
    incoming_d  = incoming_q | hit_c;
    active_d    = active_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    acc_data_d  = acc_data_q;
    err_d       = err_q;
    acc_valid_d = (state_d == ST_OUTPUT);
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (syn_if.timestep_end) begin
          active_d   = incoming_q | hit_c;
          incoming_d = '0;
          acc_d      = '0;
          idx_d      = '0;
        end
      end
      ST_ACCUM: begin
        if (syn_if.timestep_end) err_d = 1'b1;
        acc_d = sum_c;
        idx_d = idx_q + IDX_W'(1);
        if (last_idx_c) acc_data_d = sum_c;
      end
      ST_OUTPUT: begin
        if (syn_if.timestep_end) err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_Mac or negedge RST_Mac_n) begin
    if (!RST_Mac_n) begin
      incoming_q  <= '0;
      active_q    <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      acc_data_q  <= '0;
      acc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      incoming_q  <= incoming_d;
      active_q    <= active_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      acc_data_q  <= acc_data_d;
      acc_valid_q <= acc_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign syn_if.acc_valid   = acc_valid_q;
  assign syn_if.acc_data    = acc_data_q;
  assign syn_if.busy        = busy_q;
  assign syn_if.err_overrun = err_q;

endmodule
